// File: rtl/rs232_tx_arb.sv
// Round-robin arbiter sharing one RS-232 serializer among P_NREQ packet sources.
// Optional source-id header byte per packet: define RS232_TX_ARB_SRCID_EN.
module rs232_tx_arb #(
  parameter int P_NREQ    = 4,
  parameter int P_TIMEOUT = 1024,
  parameter int P_GW      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_NREQ-1:0]     req_valid,
  input  logic [8*P_NREQ-1:0]   req_data,
  input  logic [P_NREQ-1:0]     req_last,
  output logic [P_NREQ-1:0]     req_ack,
  output logic                  ser_req,
  output logic [7:0]            ser_data,
  input  logic                  ser_ack,
  output logic [P_GW-1:0]       grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int LP_IW = (P_NREQ > 1) ? $clog2(P_NREQ) : 1;
  localparam int LP_SW = LP_IW + 1;
  localparam int LP_TW = $clog2(P_TIMEOUT) + 1;
  localparam logic [LP_TW-1:0] LP_TMAX = LP_TW'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
`ifdef RS232_TX_ARB_SRCID_EN
    , S_HDR = 2'd3
`endif
  } state_t;

`ifdef RS232_TX_ARB_SRCID_EN
  function automatic logic [7:0] f_hdr(input logic [LP_IW-1:0] id);
    logic [2:0] v_id3;
    v_id3 = 3'(id);
    return {4'hA, 1'b0, v_id3};
  endfunction
`endif

  state_t              r_state, w_state;
  logic [LP_IW-1:0]    r_last_grant, w_last_grant;
  logic [P_GW-1:0]     r_grant, w_grant;
  logic [LP_TW-1:0]    r_cnt, w_cnt;
  logic                r_last, w_last;
  logic                r_ser_req, w_ser_req;
  logic [7:0]          r_ser_data, w_ser_data;
  logic [P_NREQ-1:0]   r_req_ack, w_req_ack;
  logic                r_busy, w_busy;
  logic                r_tout, w_tout;
  logic                w_found;
  logic [LP_IW-1:0]    w_winner;
  logic [LP_IW-1:0]    w_gidx;
  logic [7:0]          w_bytes [P_NREQ];

  assign w_gidx = r_grant[LP_IW-1:0];

  for (genvar gi = 0; gi < P_NREQ; gi++) begin : g_bytes
    assign w_bytes[gi] = req_data[8*gi +: 8];
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    logic [LP_SW-1:0] v_sum;
    logic [LP_IW-1:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_sum    = '0;
    v_idx    = '0;
    for (int k = 1; k <= P_NREQ; k++) begin
      v_sum = {1'b0, r_last_grant} + LP_SW'(k);
      if (v_sum >= LP_SW'(P_NREQ)) begin
        v_sum = v_sum - LP_SW'(P_NREQ);
      end else begin
        v_sum = v_sum;
      end
      v_idx = v_sum[LP_IW-1:0];
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_winner = v_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Next-state and next-output decode
  always_comb begin
    w_state      = r_state;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_cnt        = r_cnt;
    w_last       = r_last;
    w_ser_req    = r_ser_req;
    w_ser_data   = r_ser_data;
    w_req_ack    = '0;
    w_tout       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (w_found) begin
          w_grant = P_GW'(w_winner);
`ifdef RS232_TX_ARB_SRCID_EN
          w_ser_req  = 1'b1;
          w_ser_data = f_hdr(w_winner);
          w_state    = S_HDR;
`else
          w_state    = S_LOAD;
`endif
        end else begin
          w_state = S_IDLE;
        end
      end
      S_LOAD: begin
        if (req_valid[w_gidx]) begin
          w_ser_data        = w_bytes[w_gidx];
          w_last            = req_last[w_gidx];
          w_req_ack[w_gidx] = 1'b1;
          w_ser_req         = 1'b1;
          w_cnt             = '0;
          w_state           = S_SEND;
        end else if (r_cnt == LP_TMAX) begin
          w_tout       = 1'b1;
          w_last_grant = w_gidx;
          w_cnt        = '0;
          w_state      = S_IDLE;
        end else begin
          w_cnt = r_cnt + LP_TW'(1);
        end
      end
      S_SEND: begin
        if (ser_ack) begin
          w_ser_req = 1'b0;
          if (r_last) begin
            w_last_grant = w_gidx;
            w_state      = S_IDLE;
          end else begin
            w_state = S_LOAD;
          end
        end else begin
          w_state = S_SEND;
        end
      end
`ifdef RS232_TX_ARB_SRCID_EN
      S_HDR: begin
        // header carries no requester byte, so no ack and no timeout here
        if (ser_ack) begin
          w_ser_req = 1'b0;
          w_state   = S_LOAD;
        end else begin
          w_state = S_HDR;
        end
      end
`endif
      default: begin
        w_state   = S_IDLE;
        w_ser_req = 1'b0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= LP_IW'(P_NREQ - 1);
      r_grant      <= '0;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_ser_req    <= 1'b0;
      r_ser_data   <= 8'h00;
      r_req_ack    <= '0;
      r_busy       <= 1'b0;
      r_tout       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_cnt        <= w_cnt;
      r_last       <= w_last;
      r_ser_req    <= w_ser_req;
      r_ser_data   <= w_ser_data;
      r_req_ack    <= w_req_ack;
      r_busy       <= w_busy;
      r_tout       <= w_tout;
    end
  end

  assign req_ack     = r_req_ack;
  assign ser_req     = r_ser_req;
  assign ser_data    = r_ser_data;
  assign grant_id    = r_grant;
  assign busy        = r_busy;
  assign timeout_err = r_tout;

endmodule

// File: tb/tb_rs232_tx_arb.sv
// Self-checking bench for rs232_tx_arb: directed scenarios plus randomized packet rounds
// checked against a packet-level round-robin model.
module tb_rs232_tx_arb;
  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_last = '0;
  logic [NREQ-1:0]   req_ack;
  logic              ser_req;
  logic [7:0]        ser_data;
  logic              ser_ack = 1'b0;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  rs232_tx_arb #(.P_NREQ(NREQ), .P_TIMEOUT(16), .P_GW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .ser_req(ser_req), .ser_data(ser_data),
    .ser_ack(ser_ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int tout_cnt = 0;
  int m_last = NREQ - 1;
  int dly_cnt = 0;
  int dly_tgt = 1;
  logic ack_applied = 1'b0;
  logic prev_req = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] drv_q [NREQ][$];
  logic [8:0] mod_q [NREQ][$];
  logic [7:0] obs_q [$];
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (drv_q[i].size() > 0) begin
        e = drv_q[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i] = e[8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    drv_q[r].push_back({l, d});
    mod_q[r].push_back({l, d});
    drive_inputs();
  endtask

  // Packet-level reference: whole packets in round-robin order from last grant + 1.
  task automatic model_run();
    int r;
    bit found;
    logic [8:0] b;
    forever begin
      found = 1'b0;
      r = 0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && mod_q[(m_last + k) % NREQ].size() > 0) begin
          found = 1'b1;
          r = (m_last + k) % NREQ;
        end
      end
      if (!found) break;
`ifdef RS232_TX_ARB_SRCID_EN
      exp_q.push_back(8'hA0 | 8'(r));
`endif
      do begin
        b = mod_q[r].pop_front();
        exp_q.push_back(b[7:0]);
      end while (!b[8] && mod_q[r].size() > 0);
      m_last = r;
    end
  endtask

  // One clock: sample at negedge, run serializer and requester responders.
  task automatic step();
    logic [3:0] one;
    one = 4'b0001;
    @(negedge clk);
    ack_applied = ser_ack;
    ser_ack = 1'b0;
    if (timeout_err) tout_cnt++;
    if (ack_applied) begin
      chk("ser_req_drop", ser_req, 1'b0);
      dly_cnt = 0;
      dly_tgt = $urandom_range(0, 3);
      prev_req = 1'b0;
    end else if (ser_req) begin
      if (prev_req) chk("ser_data_stable", ser_data, prev_data);
      if (dly_cnt >= dly_tgt) begin
        ser_ack = 1'b1;
        obs_q.push_back(ser_data);
      end else begin
        dly_cnt++;
      end
      prev_req = 1'b1;
      prev_data = ser_data;
    end else begin
      prev_req = 1'b0;
    end
    if (req_ack != '0) begin
      chk("ack_is_grant", req_ack, one << grant_id);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i]) begin
          chk("ack_has_byte", drv_q[i].size() > 0, 1'b1);
          if (drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        end
      end
    end
    drive_inputs();
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NREQ; i++) if (drv_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && !busy && !ser_req) && n < budget);
    chk("idle_budget", n < budget, 1'b1);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int tgt;
    dly_tgt = $urandom_range(0, 3);
    // reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ser_req", ser_req, 1'b0);
    chk("rst_ser_data", ser_data, 8'h00);
    chk("rst_req_ack", req_ack, 4'h0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_tout", timeout_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // single byte from requester 0
    add_byte(0, 8'h55, 1'b1);
    model_run();
    step();
    chk("t1_busy", busy, 1'b1);
    chk("t1_grant", grant_id, 2'd0);
`ifdef RS232_TX_ARB_SRCID_EN
    chk("t1_hdr_req", ser_req, 1'b1);
    chk("t1_hdr_data", ser_data, 8'hA0);
    chk("t1_hdr_noack", req_ack, 4'h0);
`else
    chk("t1_lat_req_low", ser_req, 1'b0);
    step();
    chk("t1_lat_req_high", ser_req, 1'b1);
    chk("t1_ack", req_ack, 4'b0001);
    chk("t1_data", ser_data, 8'h55);
`endif
    run_until_idle(100);
    chk("t1_busy_fall", ack_applied, 1'b1);
    cmp_stream("t1");

    // fairness, two rounds of one-byte packets
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < NREQ; i++) add_byte(i, 8'h10 + 8'(i), 1'b1);
      model_run();
      run_until_idle(300);
      cmp_stream("t2");
    end

    // packet atomicity: requester 1 three bytes while requester 2 waits
    add_byte(1, 8'hAA, 1'b0);
    add_byte(1, 8'hBB, 1'b0);
    add_byte(1, 8'hCC, 1'b1);
    add_byte(2, 8'h5D, 1'b1);
    model_run();
    run_until_idle(300);
    cmp_stream("t3");

    // timeout: requester 3 sends a non-last byte then goes quiet, requester 0 waits
    add_byte(3, 8'hC3, 1'b0);
    add_byte(0, 8'h0D, 1'b1);
`ifdef RS232_TX_ARB_SRCID_EN
    exp_q.push_back(8'hA3);
    tgt = 2;
`else
    tgt = 1;
`endif
    exp_q.push_back(8'hC3);
`ifdef RS232_TX_ARB_SRCID_EN
    exp_q.push_back(8'hA0);
`endif
    exp_q.push_back(8'h0D);
    for (int i = 0; i < NREQ; i++) mod_q[i].delete();
    k = 0;
    do begin step(); k++; end while (!(ack_applied && obs_q.size() == tgt) && k < 60);
    chk("t4_first_budget", k < 60, 1'b1);
    chk("t4_grant", grant_id, 2'd3);
    k = 0;
    do begin step(); k++; end while (!timeout_err && k < 40);
    chk("t4_tout_delay", k, 16);
    chk("t4_busy_low", busy, 1'b0);
    chk("t4_grant_hold", grant_id, 2'd3);
    run_until_idle(100);
    chk("t4_next_grant", grant_id, 2'd0);
    chk("t4_tout_cnt", tout_cnt, 1);
    cmp_stream("t4");
    m_last = 0;

    // reset in the middle of a packet
    add_byte(1, 8'h31, 1'b0);
    add_byte(1, 8'h32, 1'b1);
    k = 0;
    do begin step(); k++; end while (!ser_req && k < 20);
    chk("t5_req_seen", ser_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ser_req", ser_req, 1'b0);
    chk("t5_req_ack", req_ack, 4'h0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_grant", grant_id, 2'd0);
    for (int i = 0; i < NREQ; i++) begin
      drv_q[i].delete();
      mod_q[i].delete();
    end
    obs_q.delete();
    exp_q.delete();
    ser_ack = 1'b0;
    prev_req = 1'b0;
    dly_cnt = 0;
    drive_inputs();
    m_last = NREQ - 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    add_byte(2, 8'h62, 1'b1);
    add_byte(0, 8'h60, 1'b1);
    model_run();
    step();
    chk("t5_first_grant", grant_id, 2'd0);
    run_until_idle(100);
    cmp_stream("t5");

    // randomized packet rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int i = 0; i < NREQ; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            add_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      model_run();
      run_until_idle(800);
      cmp_stream("rand");
    end
    chk("tout_total", tout_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
